// File: rtl/mipi_tx_lane_seq.sv
// D-PHY lane sequencer: turns a valid/ready/last byte stream into one
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11
// burst for a MIPI_TX lane. Every output is a register on CLK_IN.
module mipi_tx_lane_seq #(
  parameter int T_LPX     = 1,
  parameter int T_PREPARE = 1,
  parameter int T_ZERO    = 3,
  parameter int T_TRAIL   = 2
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       TX_REQ,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VALID,
  input  logic       TX_LAST,
  output logic       TX_READY,
  output logic       UNDERRUN,
  output logic       BUSY,
  output logic [7:0] HS_TX_DATA,
  output logic       HS_TXD_VALID,
  output logic       HS_EN,
  output logic       LP_EN,
  output logic       TX_LP_DP,
  output logic       TX_LP_DN
);

  generate
    if (T_LPX < 1 || T_LPX > 255 || T_PREPARE < 1 || T_PREPARE > 255 ||
        T_ZERO < 1 || T_ZERO > 255 || T_TRAIL < 1 || T_TRAIL > 255) begin : g_bad_param
      $fatal(1, "mipi_tx_lane_seq: timing parameters must be in 1..255");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_LPX, S_PREP, S_HSZ, S_SYNC, S_DATA, S_TRAIL, S_EXIT
  } state_t;

  localparam logic [7:0] LD_LPX    = 8'(T_LPX - 1);
  localparam logic [7:0] LD_PREP   = 8'(T_PREPARE - 1);
  localparam logic [7:0] LD_ZERO   = 8'(T_ZERO - 1);
  localparam logic [7:0] LD_TRAIL  = 8'(T_TRAIL - 1);
  localparam logic [7:0] SYNC_WORD = 8'hB8;

  state_t     r_state, w_state;
  logic [7:0] r_cnt, w_cnt;
  logic [7:0] r_hs_data, w_hs_data;
  logic       r_ready, w_ready;
  logic       r_underrun, w_underrun;
  logic       r_busy, w_busy;
  logic       r_hs_en, w_hs_en;
  logic       r_hs_valid, w_hs_valid;
  logic       r_lp_en, w_lp_en;
  logic       r_dp, w_dp;
  logic       r_dn, w_dn;
  logic [7:0] w_trail_word;

  // Trail level is the inverse of the last serialised bit (bit7, LSB-first).
  assign w_trail_word = {8{~r_hs_data[7]}};

  // Next-state, counter, data path and line levels for the state being entered.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_hs_data  = r_hs_data;
    w_ready    = 1'b0;
    w_underrun = 1'b0;
    w_lp_en    = 1'b1;
    w_dp       = 1'b1;
    w_dn       = 1'b1;
    w_hs_en    = 1'b0;
    w_hs_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (TX_REQ) begin
          w_state = S_LPX;
          w_cnt   = LD_LPX;
        end
      end
      S_LPX: begin
        if (r_cnt == '0) begin
          w_state = S_PREP;
          w_cnt   = LD_PREP;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_PREP: begin
        if (r_cnt == '0) begin
          w_state   = S_HSZ;
          w_cnt     = LD_ZERO;
          w_hs_data = '0;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_HSZ: begin
        if (r_cnt == '0) begin
          w_state   = S_SYNC;
          w_hs_data = SYNC_WORD;
          w_ready   = 1'b1;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      // TX_READY is already high while the sync word is on the lane, so SYNC
      // shares the accept logic with DATA; a missing byte there is an underrun
      // that sends no payload and trails on the sync word's bit7.
      S_SYNC, S_DATA: begin
        if (r_ready && TX_VALID) begin
          w_state   = S_DATA;
          w_hs_data = TX_DATA;
          w_ready   = ~TX_LAST;
        end else begin
          w_state    = S_TRAIL;
          w_cnt      = LD_TRAIL;
          w_hs_data  = w_trail_word;
          w_underrun = r_ready;
        end
      end
      S_TRAIL: begin
        if (r_cnt == '0) begin
          w_state   = S_EXIT;
          w_hs_data = '0;
        end else begin
          w_cnt = r_cnt - 8'd1;
        end
      end
      S_EXIT:  w_state = S_IDLE;
      default: w_state = S_IDLE;
    endcase

    case (w_state)
      S_LPX: w_dp = 1'b0;
      S_PREP: begin
        w_dp = 1'b0;
        w_dn = 1'b0;
      end
      S_HSZ, S_SYNC, S_DATA, S_TRAIL: begin
        w_lp_en    = 1'b0;
        w_dp       = 1'b0;
        w_dn       = 1'b0;
        w_hs_en    = 1'b1;
        w_hs_valid = 1'b1;
      end
      default: ;
    endcase

    w_busy = (w_state != S_IDLE);
  end

  // State and registered outputs; reset parks the lane in LP-11 at once.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_hs_data  <= '0;
      r_ready    <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
      r_hs_en    <= 1'b0;
      r_hs_valid <= 1'b0;
      r_lp_en    <= 1'b1;
      r_dp       <= 1'b1;
      r_dn       <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_hs_data  <= w_hs_data;
      r_ready    <= w_ready;
      r_underrun <= w_underrun;
      r_busy     <= w_busy;
      r_hs_en    <= w_hs_en;
      r_hs_valid <= w_hs_valid;
      r_lp_en    <= w_lp_en;
      r_dp       <= w_dp;
      r_dn       <= w_dn;
    end
  end

  assign TX_READY     = r_ready;
  assign UNDERRUN     = r_underrun;
  assign BUSY         = r_busy;
  assign HS_TX_DATA   = r_hs_data;
  assign HS_TXD_VALID = r_hs_valid;
  assign HS_EN        = r_hs_en;
  assign LP_EN        = r_lp_en;
  assign TX_LP_DP     = r_dp;
  assign TX_LP_DN     = r_dn;

endmodule

// File: tb/tb_mipi_tx_lane_seq.sv
// Directed bench for mipi_tx_lane_seq with default timing parameters.
module tb_mipi_tx_lane_seq;

  localparam int M_LP00 = 0;
  localparam int M_LP01 = 1;
  localparam int M_LP11 = 3;
  localparam int M_HS   = 4;
  localparam int M_BAD  = 7;

  logic       CLK_IN   = 1'b0;
  logic       RST      = 1'b0;
  logic       TX_REQ   = 1'b0;
  logic [7:0] TX_DATA  = '0;
  logic       TX_VALID = 1'b0;
  logic       TX_LAST  = 1'b0;
  logic       TX_READY, UNDERRUN, BUSY, HS_TXD_VALID, HS_EN, LP_EN, TX_LP_DP, TX_LP_DN;
  logic [7:0] HS_TX_DATA;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] src_q[$];
  bit         src_has_last;

  mipi_tx_lane_seq #(
    .T_LPX(1), .T_PREPARE(1), .T_ZERO(3), .T_TRAIL(2)
  ) dut (
    .CLK_IN(CLK_IN), .RST(RST), .TX_REQ(TX_REQ), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_LAST(TX_LAST), .TX_READY(TX_READY),
    .UNDERRUN(UNDERRUN), .BUSY(BUSY), .HS_TX_DATA(HS_TX_DATA),
    .HS_TXD_VALID(HS_TXD_VALID), .HS_EN(HS_EN), .LP_EN(LP_EN),
    .TX_LP_DP(TX_LP_DP), .TX_LP_DN(TX_LP_DN)
  );

  always #5 CLK_IN = ~CLK_IN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Lane condition seen on the outputs: LP code {DP,DN}, HS, or inconsistent.
  function automatic int mode_of(input logic lp, input logic hs, input logic v,
                                 input logic dp, input logic dn);
    if (lp && !hs && !v) return int'({dp, dn});
    if (hs && !lp && v) return M_HS;
    return M_BAD;
  endfunction

  task automatic src_present();
    if (src_q.size() > 0) begin
      TX_VALID = 1'b1;
      TX_DATA  = src_q[0];
      TX_LAST  = src_has_last && (src_q.size() == 1);
    end else begin
      TX_VALID = 1'b0;
      TX_DATA  = '0;
      TX_LAST  = 1'b0;
    end
  endtask

  // Advance one clock, feed the byte source on handshakes, check the cycle.
  task automatic cyc(input string tag, input int mode, input logic [7:0] data,
                     input logic rdy, input logic urun, input logic busy);
    logic hs;
    hs = TX_VALID & TX_READY;
    @(posedge CLK_IN);
    #1;
    if (hs) begin
      void'(src_q.pop_front());
      src_present();
    end
    check({tag, ".mode"}, mode_of(LP_EN, HS_EN, HS_TXD_VALID, TX_LP_DP, TX_LP_DN), mode);
    if (mode == M_HS) check({tag, ".data"}, HS_TX_DATA, data);
    check({tag, ".ready"}, TX_READY, rdy);
    check({tag, ".urun"}, UNDERRUN, urun);
    check({tag, ".busy"}, BUSY, busy);
  endtask

  task automatic preamble(input string tag);
    cyc({tag, ".lpx"}, M_LP01, 8'h00, 0, 0, 1);
    TX_REQ = 1'b0;
    cyc({tag, ".prep"}, M_LP00, 8'h00, 0, 0, 1);
    cyc({tag, ".hsz0"}, M_HS, 8'h00, 0, 0, 1);
    cyc({tag, ".hsz1"}, M_HS, 8'h00, 0, 0, 1);
    cyc({tag, ".hsz2"}, M_HS, 8'h00, 0, 0, 1);
    cyc({tag, ".sync"}, M_HS, 8'hB8, 1, 0, 1);
  endtask

  // HS_EN and LP_EN must never be high together.
  always @(negedge CLK_IN) check("hs_lp_excl", HS_EN & LP_EN, 0);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // 1: reset values
    repeat (2) @(posedge CLK_IN);
    #1;
    check("rst.lp_en", LP_EN, 1);
    check("rst.dp", TX_LP_DP, 1);
    check("rst.dn", TX_LP_DN, 1);
    check("rst.hs_en", HS_EN, 0);
    check("rst.hs_valid", HS_TXD_VALID, 0);
    check("rst.hs_data", HS_TX_DATA, 8'h00);
    check("rst.ready", TX_READY, 0);
    check("rst.urun", UNDERRUN, 0);
    check("rst.busy", BUSY, 0);
    @(negedge CLK_IN) RST = 1'b1;
    cyc("idle", M_LP11, 8'h00, 0, 0, 0);

    // 2: three bytes, no gaps
    src_q = {8'h11, 8'h22, 8'h33};
    src_has_last = 1'b1;
    src_present();
    TX_REQ = 1'b1;
    preamble("t2");
    cyc("t2.d0", M_HS, 8'h11, 1, 0, 1);
    cyc("t2.d1", M_HS, 8'h22, 1, 0, 1);
    cyc("t2.d2", M_HS, 8'h33, 0, 0, 1);
    cyc("t2.tr0", M_HS, 8'hFF, 0, 0, 1);
    cyc("t2.tr1", M_HS, 8'hFF, 0, 0, 1);
    cyc("t2.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t2.idle", M_LP11, 8'h00, 0, 0, 0);

    // 3: single byte with bit7 set -> trail 0x00
    src_q = {8'h80};
    src_has_last = 1'b1;
    src_present();
    TX_REQ = 1'b1;
    preamble("t3");
    cyc("t3.d0", M_HS, 8'h80, 0, 0, 1);
    cyc("t3.tr0", M_HS, 8'h00, 0, 0, 1);
    cyc("t3.tr1", M_HS, 8'h00, 0, 0, 1);
    cyc("t3.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t3.idle", M_LP11, 8'h00, 0, 0, 0);

    // 4: source runs dry after one byte, no LAST
    src_q = {8'h11};
    src_has_last = 1'b0;
    src_present();
    TX_REQ = 1'b1;
    preamble("t4");
    cyc("t4.d0", M_HS, 8'h11, 1, 0, 1);
    cyc("t4.tr0", M_HS, 8'hFF, 0, 1, 1);
    cyc("t4.tr1", M_HS, 8'hFF, 0, 0, 1);
    cyc("t4.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t4.idle", M_LP11, 8'h00, 0, 0, 0);

    // 5: reset asserted in DATA, then a burst with no payload at all
    src_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
    src_has_last = 1'b1;
    src_present();
    TX_REQ = 1'b1;
    preamble("t5");
    cyc("t5.d0", M_HS, 8'hAA, 1, 0, 1);
    RST = 1'b0;
    #1;
    check("t5.rst.lp_en", LP_EN, 1);
    check("t5.rst.hs_en", HS_EN, 0);
    check("t5.rst.dp", TX_LP_DP, 1);
    check("t5.rst.dn", TX_LP_DN, 1);
    check("t5.rst.busy", BUSY, 0);
    check("t5.rst.ready", TX_READY, 0);
    @(negedge CLK_IN);
    RST = 1'b1;
    src_q.delete();
    src_present();
    TX_REQ = 1'b1;
    preamble("t5b");
    cyc("t5b.tr0", M_HS, 8'h00, 0, 1, 1);
    cyc("t5b.tr1", M_HS, 8'h00, 0, 0, 1);
    cyc("t5b.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t5b.idle", M_LP11, 8'h00, 0, 0, 0);

    // 6: TX_REQ held high across EXIT -> one IDLE cycle, then next LP-01
    src_q = {8'h5A};
    src_has_last = 1'b1;
    src_present();
    TX_REQ = 1'b1;
    cyc("t6.lpx", M_LP01, 8'h00, 0, 0, 1);
    cyc("t6.prep", M_LP00, 8'h00, 0, 0, 1);
    cyc("t6.hsz0", M_HS, 8'h00, 0, 0, 1);
    cyc("t6.hsz1", M_HS, 8'h00, 0, 0, 1);
    cyc("t6.hsz2", M_HS, 8'h00, 0, 0, 1);
    cyc("t6.sync", M_HS, 8'hB8, 1, 0, 1);
    cyc("t6.d0", M_HS, 8'h5A, 0, 0, 1);
    cyc("t6.tr0", M_HS, 8'hFF, 0, 0, 1);
    cyc("t6.tr1", M_HS, 8'hFF, 0, 0, 1);
    cyc("t6.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t6.idle", M_LP11, 8'h00, 0, 0, 0);
    src_q = {8'h77};
    src_has_last = 1'b1;
    src_present();
    preamble("t6b");
    cyc("t6b.d0", M_HS, 8'h77, 0, 0, 1);
    cyc("t6b.tr0", M_HS, 8'hFF, 0, 0, 1);
    cyc("t6b.tr1", M_HS, 8'hFF, 0, 0, 1);
    cyc("t6b.exit", M_LP11, 8'h00, 0, 0, 1);
    cyc("t6b.idle", M_LP11, 8'h00, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
